// File: rtl/alu_pkg.sv
// alu_pkg: shared alu widths, sweep controller states and the result bundle
package alu_pkg;
    localparam int DW = 4;
    localparam int YW = 8;
    localparam int SW = 3;
    localparam int NUM_OPS_MAX = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    typedef struct packed {
        logic [YW-1:0] data;
        logic [SW-1:0] sel;
        logic last;
    } res_t;
endpackage

// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: takes an operand pair, sweeps alu sel over NUM_OPS ops and streams each captured result
module alu_sweep_ctrl #(
    parameter int DW = alu_pkg::DW,
    parameter int YW = alu_pkg::YW,
    parameter int SW = alu_pkg::SW,
    parameter int NUM_OPS = alu_pkg::NUM_OPS_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [SW-1:0] alu_sel,
    input  logic [YW-1:0] alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [YW-1:0] res_data,
    output logic [SW-1:0] res_sel,
    output logic          res_last,
    output logic          busy
);
    import alu_pkg::*;
    state_t state, state_d;
    res_t res, res_d;
    logic [DW-1:0] a_d, b_d;
    logic [SW-1:0] sel_d;
    logic valid_d;
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign res_data = res.data;
    assign res_sel = res.sel;
    assign res_last = res.last;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            alu_a <= '0;
            alu_b <= '0;
            alu_sel <= '0;
            res <= '0;
            res_valid <= 1'b0;
        end else begin
            state <= state_d;
            alu_a <= a_d;
            alu_b <= b_d;
            alu_sel <= sel_d;
            res <= res_d;
            res_valid <= valid_d;
        end
    end
    always_comb begin
        state_d = state;
        a_d = alu_a;
        b_d = alu_b;
        sel_d = alu_sel;
        res_d = res;
        valid_d = res_valid;
        case (state)
            IDLE: begin
                a_d = in_valid ? in_a : alu_a;
                b_d = in_valid ? in_b : alu_b;
                sel_d = in_valid ? '0 : alu_sel;
                state_d = in_valid ? ISSUE : IDLE;
            end
            ISSUE: begin
                res_d = '{data: alu_y, sel: alu_sel, last: alu_sel == SW'(NUM_OPS - 1)};
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                valid_d = res_ready ? 1'b0 : res_valid;
                sel_d = (res_ready && !res.last) ? alu_sel + SW'(1) : alu_sel;
                state_d = !res_ready ? HOLD : res.last ? IDLE : ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// tb_alu_sweep_ctrl: randomized self-checking bench for alu_sweep_ctrl with an xor/sel alu stub
module tb_alu_sweep_ctrl;
    logic clk = 0;
    logic rst_n = 0;
    logic in_valid = 0, in_ready, res_valid, res_ready = 1, res_last, busy;
    logic [3:0] in_a = 0, in_b = 0, alu_a, alu_b;
    logic [2:0] alu_sel, res_sel;
    logic [7:0] alu_y, res_data;
    logic s_in_valid = 0, s_in_ready, s_res_valid, s_res_ready = 1, s_res_last, s_busy;
    logic [3:0] s_in_a = 0, s_in_b = 0, s_alu_a, s_alu_b;
    logic [2:0] s_alu_sel, s_res_sel;
    logic [7:0] s_alu_y, s_res_data;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    assign alu_y = {1'b0, alu_sel, alu_a ^ alu_b};
    assign s_alu_y = {1'b0, s_alu_sel, s_alu_a ^ s_alu_b};

    alu_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_sel(res_sel), .res_last(res_last), .busy(busy)
    );

    alu_sweep_ctrl #(.NUM_OPS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_sel(s_alu_sel),
        .alu_y(s_alu_y), .res_valid(s_res_valid), .res_ready(s_res_ready), .res_data(s_res_data),
        .res_sel(s_res_sel), .res_last(s_res_last), .busy(s_busy)
    );

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, busy, res_valid, res_last} !== 4'b1000 || alu_a !== 0 || alu_b !== 0 ||
            alu_sel !== 0 || res_data !== 0 || res_sel !== 0) begin
            fails++;
            $display("FAIL reset: rdy=%b busy=%b vld=%b last=%b a=%h b=%h sel=%0d data=%h rsel=%0d, want 1 0 0 0 0 0 0 00 0",
                     in_ready, busy, res_valid, res_last, alu_a, alu_b, alu_sel, res_data, res_sel);
        end
        tests++;
        if ({s_in_ready, s_busy, s_res_valid} !== 3'b100) begin
            fails++;
            $display("FAIL reset_single: rdy=%b busy=%b vld=%b, want 1 0 0", s_in_ready, s_busy, s_res_valid);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; the pair is accepted on the next posedge.
    task automatic offer(input logic [3:0] a, input logic [3:0] b);
        in_valid = 1;
        in_a = a;
        in_b = b;
        tests++;
        if (in_ready !== 1) begin
            fails++;
            $display("FAIL offer_ready: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 0;
    endtask

    // Consumes one 8-op transaction; expected result for op k is {0, k, a^b}.
    task automatic collect(input logic [3:0] a, input logic [3:0] b, input int stall_at,
                           input int stall_len, input int abort_at, input bit junk);
        int idx = 0, prev = -1, left = stall_len, cyc = 0;
        bit seen = 0, stalled = 0;
        logic [7:0] exp;
        res_ready = 1;
        if (junk) begin
            in_valid = 1;
            in_a = 4'h0;
        end
        while (idx < 8 && cyc < 100) begin
            tests++;
            if (in_ready !== 0 || busy !== 1) begin
                fails++;
                $display("FAIL busy_flags: op %0d in_ready=%b busy=%b, want 0 1", idx, in_ready, busy);
            end
            if (res_valid === 1) begin
                exp = {1'b0, 3'(idx), a ^ b};
                if (!seen) begin
                    seen = 1;
                    tests++;
                    if (cyc - prev != 2) begin
                        fails++;
                        $display("FAIL latency: op %0d valid after %0d cycles, want 2", idx, cyc - prev);
                    end
                end
                tests++;
                if (res_data !== exp || res_sel !== 3'(idx) || res_last !== (idx == 7)) begin
                    fails++;
                    $display("FAIL result: op %0d data=%h sel=%0d last=%b, want %h %0d %b",
                             idx, res_data, res_sel, res_last, exp, idx, idx == 7);
                end
                if (idx == abort_at) begin
                    rst_n = 0;
                    res_ready = 0;
                    @(negedge clk);
                    rst_n = 1;
                    res_ready = 1;
                    tests++;
                    if ({res_valid, res_last, busy, in_ready} !== 4'b0001 || alu_sel !== 0) begin
                        fails++;
                        $display("FAIL abort: vld=%b last=%b busy=%b rdy=%b sel=%0d, want 0 0 0 1 0",
                                 res_valid, res_last, busy, in_ready, alu_sel);
                    end
                    return;
                end
                if (idx == stall_at && left > 0) begin
                    res_ready = 0;
                    stalled = 1;
                    left--;
                end else begin
                    res_ready = 1;
                    stalled = 0;
                    prev = cyc;
                    seen = 0;
                    idx++;
                end
            end else begin
                if (stalled) begin
                    tests++;
                    fails++;
                    $display("FAIL stall_drop: op %0d res_valid=%b while stalled, want 1", idx, res_valid);
                    stalled = 0;
                end
                res_ready = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (idx != 8) begin
            fails++;
            $display("FAIL timeout: %0d results seen, want 8", idx);
        end
        tests++;
        if ({in_ready, busy, res_valid} !== 3'b100 || alu_a !== (junk ? a : a) || alu_b !== b || alu_sel !== 3'd7) begin
            fails++;
            $display("FAIL done: rdy=%b busy=%b vld=%b a=%h b=%h sel=%0d, want 1 0 0 %h %h 7",
                     in_ready, busy, res_valid, alu_a, alu_b, alu_sel, a, b);
        end
        res_ready = 1;
    endtask

    task automatic test_sweep();
        offer(4'hD, 4'hB);
        collect(4'hD, 4'hB, -1, 0, -1, 0);
    endtask

    task automatic test_stall();
        offer(4'hD, 4'hB);
        collect(4'hD, 4'hB, 3, 5, -1, 0);
    endtask

    task automatic test_busy_ignore();
        offer(4'hD, 4'hB);
        collect(4'hD, 4'hB, -1, 0, -1, 1);
        @(negedge clk);
        in_valid = 0;
        collect(4'h0, 4'hB, -1, 0, -1, 0);
    endtask

    task automatic test_abort();
        offer(4'hD, 4'hB);
        collect(4'hD, 4'hB, -1, 0, 5, 0);
        offer(4'h6, 4'h9);
        collect(4'h6, 4'h9, -1, 0, -1, 0);
    endtask

    task automatic test_single_op();
        s_in_valid = 1;
        s_in_a = 4'h3;
        s_in_b = 4'h1;
        s_res_ready = 1;
        tests++;
        if (s_in_ready !== 1) begin
            fails++;
            $display("FAIL single_ready: in_ready=%b, want 1", s_in_ready);
        end
        @(negedge clk);
        s_in_valid = 0;
        tests++;
        if (s_res_valid !== 0 || s_busy !== 1) begin
            fails++;
            $display("FAIL single_issue: vld=%b busy=%b, want 0 1", s_res_valid, s_busy);
        end
        @(negedge clk);
        tests++;
        if (s_res_valid !== 1 || s_res_data !== 8'h02 || s_res_sel !== 0 || s_res_last !== 1) begin
            fails++;
            $display("FAIL single_result: vld=%b data=%h sel=%0d last=%b, want 1 02 0 1",
                     s_res_valid, s_res_data, s_res_sel, s_res_last);
        end
        @(negedge clk);
        tests++;
        if (s_res_valid !== 0 || s_in_ready !== 1 || s_busy !== 0 || s_alu_sel !== 0) begin
            fails++;
            $display("FAIL single_done: vld=%b rdy=%b busy=%b sel=%0d, want 0 1 0 0",
                     s_res_valid, s_in_ready, s_busy, s_alu_sel);
        end
    endtask

    task automatic test_back_to_back();
        offer(4'hD, 4'hB);
        collect(4'hD, 4'hB, -1, 0, -1, 0);
        offer(4'hF, 4'h0);
        collect(4'hF, 4'h0, -1, 0, -1, 0);
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            offer(a, b);
            collect(a, b, int'($urandom_range(0, 8)), int'($urandom_range(1, 6)), -1, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_sweep();
        test_stall();
        test_busy_ignore();
        test_abort();
        test_single_op();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
